// File: rtl/pb_sched_pkg.sv
// Shared widths, helpers and types for the push-button counter scheduler.
package pb_sched_pkg;

  localparam int unsigned DEF_N_BTN       = 4;
  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  // Channel-id width; a single channel still needs one bit of id.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [DEF_CNT_W-1:0] cnt_word_t;

endpackage

// File: rtl/pb_edge_sync.sv
// Per-button synchroniser chain followed by a rising-edge one-shot.
module pb_edge_sync
  import pb_sched_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic rise_c_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // High for exactly one cycle after the synchronised level goes 0->1.
  assign rise_c_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pb_count_sched.sv
// Push-button request latching with a round-robin scheduler that shares one
// counter-increment path across all channels.
module pb_count_sched
  import pb_sched_pkg::*;
#(
  parameter int unsigned N_BTN       = DEF_N_BTN,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  localparam int unsigned ID_W       = clog2_min1(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn,
  input  logic             clr,
  input  logic [ID_W-1:0]  rd_sel,
  output logic [CNT_W-1:0] rd_count,
  output logic             upd_valid,
  output logic [ID_W-1:0]  upd_id,
  output logic [CNT_W-1:0] upd_count,
  output logic [N_BTN-1:0] pending,
  output logic [N_BTN-1:0] wrapped,
  output logic [N_BTN-1:0] missed
);

  typedef logic [CNT_W-1:0] cnt_t;

  logic [N_BTN-1:0] rise;

  cnt_t             cnt_q [N_BTN];
  cnt_t             cnt_d [N_BTN];
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] wrap_q, wrap_d;
  logic [N_BTN-1:0] miss_q, miss_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             upd_valid_q, upd_valid_d;
  logic [ID_W-1:0]  upd_id_q, upd_id_d;
  cnt_t             upd_count_q, upd_count_d;

  logic             gnt_valid;
  logic [ID_W-1:0]  gnt_id;
  cnt_t             gnt_cnt;
  cnt_t             gnt_inc;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    pb_edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_i    (btn[i]),
      .rise_c_o (rise[i])
    );
  end

  // Round-robin pick: first pending bit at or after ptr, wrapping modulo N_BTN.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N_BTN; k++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(N_BTN)) begin
        sum = sum - (ID_W+1)'(N_BTN);
      end
      idx = sum[ID_W-1:0];
      if (!gnt_valid && pend_q[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  assign gnt_cnt = cnt_q[gnt_id];
  assign gnt_inc = gnt_cnt + CNT_W'(1);

  always_comb begin
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    wrap_d      = wrap_q;
    miss_d      = miss_q;
    ptr_d       = ptr_q;
    upd_valid_d = 1'b0;
    upd_id_d    = upd_id_q;
    upd_count_d = upd_count_q;

    if (clr) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_d[i] = '0;
      end
      pend_d = '0;
      wrap_d = '0;
      miss_d = '0;
      ptr_d  = '0;
    end else begin
      if (gnt_valid) begin
        cnt_d[gnt_id] = gnt_inc;
        pend_d[gnt_id] = 1'b0;
        if (gnt_cnt == {CNT_W{1'b1}}) begin
          wrap_d[gnt_id] = 1'b1;
        end
        upd_valid_d = 1'b1;
        upd_id_d    = gnt_id;
        upd_count_d = gnt_inc;
        ptr_d       = (gnt_id == ID_W'(N_BTN - 1)) ? '0 : gnt_id + ID_W'(1);
      end
      // An edge landing on the channel being granted becomes a fresh request.
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (rise[i]) begin
          if (pend_q[i] && !(gnt_valid && (gnt_id == ID_W'(i)))) begin
            miss_d[i] = 1'b1;
          end else begin
            pend_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
      pend_q      <= '0;
      wrap_q      <= '0;
      miss_q      <= '0;
      ptr_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_id_q    <= '0;
      upd_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      wrap_q      <= wrap_d;
      miss_q      <= miss_d;
      ptr_q       <= ptr_d;
      upd_valid_q <= upd_valid_d;
      upd_id_q    <= upd_id_d;
      upd_count_q <= upd_count_d;
    end
  end

  always_comb begin
    rd_count = '0;
    if (32'(rd_sel) < N_BTN) begin
      rd_count = cnt_q[rd_sel];
    end
  end

  assign upd_valid = upd_valid_q;
  assign upd_id    = upd_id_q;
  assign upd_count = upd_count_q;
  assign pending   = pend_q;
  assign wrapped   = wrap_q;
  assign missed    = miss_q;

endmodule

// File: tb/tb_pb_count_sched.sv
// Directed bench for pb_count_sched: press timing, contention, fairness, wrap,
// missed/re-request, clear and asynchronous reset.
module tb_pb_count_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic       clr;
  logic [1:0] rd_sel;
  logic [7:0] rd_count;
  logic       upd_valid;
  logic [1:0] upd_id;
  logic [7:0] upd_count;
  logic [3:0] pending;
  logic [3:0] wrapped;
  logic [3:0] missed;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int pulses;

  always #5 clk = ~clk;

  pb_count_sched #(
    .N_BTN      (4),
    .CNT_W      (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .clr      (clr),
    .rd_sel   (rd_sel),
    .rd_count (rd_count),
    .upd_valid(upd_valid),
    .upd_id   (upd_id),
    .upd_count(upd_count),
    .pending  (pending),
    .wrapped  (wrapped),
    .missed   (missed)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_upd(input string tag, input logic [1:0] id, input logic [7:0] cnt);
    chk({tag, ".valid"}, 32'(upd_valid), 32'd1);
    chk({tag, ".id"}, 32'(upd_id), 32'(id));
    chk({tag, ".count"}, 32'(upd_count), 32'(cnt));
  endtask

  task automatic chk_rd(input string tag, input int ch, input logic [7:0] exp);
    rd_sel = 2'(ch);
    #1;
    chk(tag, 32'(rd_count), 32'(exp));
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic settle();
    btn = 4'b0000;
    repeat (3) tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    btn    = 4'b0000;
    clr    = 1'b0;
    rd_sel = 2'd0;
    repeat (2) tick();
    chk("rst.upd_valid", 32'(upd_valid), 32'd0);
    chk("rst.upd_id", 32'(upd_id), 32'd0);
    chk("rst.upd_count", 32'(upd_count), 32'd0);
    chk("rst.pending", 32'(pending), 32'd0);
    chk("rst.wrapped", 32'(wrapped), 32'd0);
    chk("rst.missed", 32'(missed), 32'd0);
    chk_rd("rst.rd_count", 0, 8'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single press on channel 1: pending at E0+2, update at E0+3.
    btn = 4'b0010;
    tick();
    chk("single.pend_e0", 32'(pending), 32'h0);
    tick();
    chk("single.pend_e1", 32'(pending), 32'h0);
    tick();
    chk("single.pend_e2", 32'(pending), 32'h2);
    chk("single.valid_e2", 32'(upd_valid), 32'd0);
    tick();
    chk_upd("single.upd", 2'd1, 8'd1);
    chk("single.pend_after", 32'(pending), 32'h0);
    chk_rd("single.rd1", 1, 8'd1);
    pulses = 0;
    repeat (6) begin
      tick();
      if (upd_valid) pulses++;
    end
    chk("single.extra_pulses", 32'(pulses), 32'd0);
    settle();

    clr_pulse();
    chk("clr1.pending", 32'(pending), 32'h0);
    chk_rd("clr1.rd1", 1, 8'd0);

    // Contention: four simultaneous presses served in order 0..3 from ptr=0.
    btn = 4'b1111;
    repeat (3) tick();
    chk("cont.pending", 32'(pending), 32'hF);
    chk("cont.valid0", 32'(upd_valid), 32'd0);
    for (int g = 0; g < 4; g++) begin
      tick();
      chk_upd("cont.upd", 2'(g), 8'd1);
    end
    chk("cont.pend_empty", 32'(pending), 32'h0);
    tick();
    chk("cont.idle", 32'(upd_valid), 32'd0);
    for (int c = 0; c < 4; c++) chk_rd("cont.rd", c, 8'd1);
    settle();

    // Fairness: after serving 2, simultaneous {0,3} go 3 then 0.
    btn = 4'b0100;
    repeat (4) tick();
    chk_upd("rr.g2", 2'd2, 8'd2);
    settle();
    btn = 4'b1001;
    repeat (3) tick();
    chk("rr.pending", 32'(pending), 32'h9);
    tick();
    chk_upd("rr.first", 2'd3, 8'd2);
    tick();
    chk_upd("rr.second", 2'd0, 8'd2);
    settle();

    // Channel 3 re-pressed while still waiting: dropped and flagged.
    clr_pulse();
    btn = 4'b1111;
    tick();
    btn = 4'b0111;
    tick();
    tick();
    chk("miss.pending", 32'(pending), 32'hF);
    btn = 4'b1111;
    tick();
    chk_upd("miss.g0", 2'd0, 8'd1);
    tick();
    chk_upd("miss.g1", 2'd1, 8'd1);
    chk("miss.flag_early", 32'(missed), 32'h0);
    tick();
    chk_upd("miss.g2", 2'd2, 8'd1);
    chk("miss.flag", 32'(missed), 32'h8);
    tick();
    chk_upd("miss.g3", 2'd3, 8'd1);
    tick();
    chk("miss.idle", 32'(upd_valid), 32'd0);
    chk("miss.pend_empty", 32'(pending), 32'h0);
    chk_rd("miss.rd3", 3, 8'd1);
    settle();

    // Re-press landing exactly on the grant of channel 1 becomes a new request.
    clr_pulse();
    btn = 4'b0011;
    tick();
    btn = 4'b0001;
    tick();
    btn = 4'b0011;
    tick();
    chk("rereq.pending", 32'(pending), 32'h3);
    tick();
    chk_upd("rereq.g0", 2'd0, 8'd1);
    tick();
    chk_upd("rereq.g1", 2'd1, 8'd1);
    chk("rereq.pend_kept", 32'(pending), 32'h2);
    chk("rereq.missed0", 32'(missed), 32'h0);
    tick();
    chk_upd("rereq.g1b", 2'd1, 8'd2);
    chk("rereq.missed1", 32'(missed), 32'h0);
    chk("rereq.pend_empty", 32'(pending), 32'h0);
    tick();
    chk("rereq.idle", 32'(upd_valid), 32'd0);
    settle();

    // Wrap: 255 presses reach 255, the 256th wraps to 0.
    clr_pulse();
    repeat (255) begin
      btn = 4'b0001;
      tick();
      tick();
      btn = 4'b0000;
      tick();
      tick();
    end
    chk_rd("wrap.rd255", 0, 8'd255);
    chk("wrap.count255", 32'(upd_count), 32'd255);
    chk("wrap.flag_pre", 32'(wrapped), 32'h0);
    btn = 4'b0001;
    tick();
    tick();
    btn = 4'b0000;
    tick();
    tick();
    chk_upd("wrap.upd0", 2'd0, 8'd0);
    chk("wrap.flag", 32'(wrapped), 32'h1);
    chk("wrap.missed", 32'(missed), 32'h0);
    settle();

    // Clear with three requests pending; held buttons are not re-counted.
    btn = 4'b0111;
    repeat (3) tick();
    chk("clr2.pend_pre", 32'(pending), 32'h7);
    clr_pulse();
    chk("clr2.valid", 32'(upd_valid), 32'd0);
    chk("clr2.pending", 32'(pending), 32'h0);
    chk("clr2.wrapped", 32'(wrapped), 32'h0);
    chk("clr2.missed", 32'(missed), 32'h0);
    chk_rd("clr2.rd0", 0, 8'd0);
    pulses = 0;
    repeat (4) begin
      tick();
      if (upd_valid || (pending != 4'h0)) pulses++;
    end
    chk("clr2.no_recount", 32'(pulses), 32'd0);
    settle();

    // Asynchronous reset mid-burst, then a held button counts once after release.
    btn = 4'b1111;
    repeat (4) tick();
    chk_upd("rstm.g0", 2'd0, 8'd1);
    tick();
    chk_upd("rstm.g1", 2'd1, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm.valid", 32'(upd_valid), 32'd0);
    chk("rstm.id", 32'(upd_id), 32'd0);
    chk("rstm.count", 32'(upd_count), 32'd0);
    chk("rstm.pending", 32'(pending), 32'h0);
    chk_rd("rstm.rd1", 1, 8'd0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rstm.pend_early", 32'(pending), 32'h0);
    tick();
    chk("rstm.pend_held", 32'(pending), 32'hF);
    tick();
    chk_upd("rstm.g0_after", 2'd0, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
